// File: rtl/instr_enc_pkg.sv
// +----------------------------------------------------------------------------+
// | instr_enc_pkg                                                              |
// | Shared types, opcode constants and pack/check/extract helpers for the     |
// | RV32I instruction encoder.                                                 |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package instr_enc_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] LUI    = 7'h37;
  localparam logic [6:0] BRANCH = 7'h63;
  localparam logic [6:0] JAL    = 7'h6F;
  localparam logic [6:0] STORE  = 7'h23;
  localparam logic [6:0] OP     = 7'h33;

  // fmt kept as raw bits so the illegal codes 6/7 remain representable
  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } enc_req_t;

  function automatic logic [31:0] pack_word(input enc_req_t r);
    logic [31:0] w;
    w = 32'd0;
    case (r.fmt)
      FMT_R: w = {r.funct7, r.rs2, r.rs1, r.funct3, r.rd, r.opcode};
      FMT_I: w = {r.imm[11:0], r.rs1, r.funct3, r.rd, r.opcode};
      FMT_S: w = {r.imm[11:5], r.rs2, r.rs1, r.funct3, r.imm[4:0], r.opcode};
      FMT_B: w = {r.imm[12], r.imm[10:5], r.rs2, r.rs1, r.funct3,
                  r.imm[4:1], r.imm[11], r.opcode};
      FMT_U: w = {r.imm[31:12], r.rd, r.opcode};
      FMT_J: w = {r.imm[20], r.imm[10:1], r.imm[11], r.imm[19:12], r.rd, r.opcode};
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  // A field is representable when every bit above the encoded range matches the sign
  function automatic logic imm_err(input enc_req_t r);
    logic e;
    e = 1'b0;
    case (r.fmt)
      FMT_R: e = 1'b0;
      FMT_I,
      FMT_S: e = !((&r.imm[31:11]) || !(|r.imm[31:11]));
      FMT_B: e = !((&r.imm[31:12]) || !(|r.imm[31:12])) || r.imm[0];
      FMT_U: e = |r.imm[11:0];
      FMT_J: e = !((&r.imm[31:20]) || !(|r.imm[31:20])) || r.imm[0];
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] extract_imm(input logic [2:0] fmt, input logic [31:0] w);
    logic [31:0] i;
    i = 32'd0;
    case (fmt)
      FMT_I: i = {{20{w[31]}}, w[31:20]};
      FMT_S: i = {{20{w[31]}}, w[31:25], w[11:7]};
      FMT_B: i = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      FMT_U: i = {w[31:12], 12'd0};
      FMT_J: i = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: i = 32'd0;
    endcase
    return i;
  endfunction

endpackage

`default_nettype wire

// File: rtl/enc_fifo.sv
// +----------------------------------------------------------------------------+
// | enc_fifo                                                                   |
// | Synchronous FIFO carrying {word, err}; async active-low reset.            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module enc_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign full      = (r_count == C_FULL);
  assign empty     = (r_count == '0);
  assign w_pop_ok  = pop && !empty;
  // A push into a full FIFO is legal only when the head leaves in the same cycle
  assign w_push_ok = push && (!full || w_pop_ok);
  assign pop_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
// +----------------------------------------------------------------------------+
// | instr_encoder                                                              |
// | Packs decoded RV32I fields + immediate into an instruction word, with     |
// | range checking and an output FIFO. Optional round-trip self-check is      |
// | enabled by INSTR_ENC_ROUNDTRIP_CHK_EN.                                     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count,
  output logic             rt_fail
);

  enc_req_t   w_req;
  logic       w_accept;
  logic       w_s1_adv;
  logic       w_fifo_full;
  logic       w_fifo_empty;
  logic       r_s1_valid;
  logic [31:0] r_s1_word;
  logic       r_s1_err;
  logic [CNT_W-1:0] r_err_count;

  assign w_req = '{fmt: in_fmt, opcode: in_opcode, rd: in_rd, rs1: in_rs1,
                   rs2: in_rs2, funct3: in_funct3, funct7: in_funct7, imm: in_imm};

  assign in_ready = !r_s1_valid || !w_fifo_full;
  assign w_accept = in_valid && in_ready;
  assign w_s1_adv = r_s1_valid && !w_fifo_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_word  <= 32'd0;
      r_s1_err   <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_word  <= pack_word(w_req);
      r_s1_err   <= imm_err(w_req);
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (w_s1_adv && r_s1_err && (r_err_count != '1)) begin
      r_err_count <= r_err_count + CNT_W'(1);
    end
  end

  assign err_count = r_err_count;
  assign out_valid = !w_fifo_empty;

  enc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (33)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_s1_adv),
    .push_data ({r_s1_word, r_s1_err}),
    .full      (w_fifo_full),
    .pop       (out_ready),
    .pop_data  ({out_instr, out_err}),
    .empty     (w_fifo_empty)
  );

`ifdef INSTR_ENC_ROUNDTRIP_CHK_EN
  logic [2:0]  r_s1_fmt;
  logic [31:0] r_s1_imm;
  logic        r_rt_fail;
  logic [31:0] w_rt_imm;

  assign w_rt_imm = extract_imm(r_s1_fmt, r_s1_word);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_fmt <= 3'd0;
      r_s1_imm <= 32'd0;
    end else if (w_accept) begin
      r_s1_fmt <= in_fmt;
      r_s1_imm <= in_imm;
    end
  end

  // Checked once per entry, as it leaves S1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rt_fail <= 1'b0;
    end else if (w_s1_adv && !r_s1_err && (r_s1_fmt != FMT_R) && (w_rt_imm != r_s1_imm)) begin
      r_rt_fail <= 1'b1;
    end
  end

  assign rt_fail = r_rt_fail;
`else
  assign rt_fail = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Packs decoded RV32I instruction fields plus a 32-bit sign-extended immediate back into a 32-bit instruction word.
- This is the inverse of the core's immediate-extraction path.
- Sits between the debug/instruction-injection front end and the instruction memory write port.
- Valid/ready handshake on both sides:
  - One registered packing stage.
  - A small output FIFO for backpressure.
  - Range/alignment checking of the immediate against the selected format.

Parameters:
- FIFO_DEPTH, 2, output FIFO entries (power of 2, ≥2).
- CNT_W, 16, width of saturating error counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder can accept.
- in_fmt  in  3  format: R=0, I=1, S=2, B=3, U=4, J=5; 6,7 illegal.
- in_opcode  in  7  opcode field.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_funct3  in  3  funct3 field.
- in_funct7  in  7  funct7 field.
- in_imm  in  32  sign-extended immediate (U: full upper value, low 12 bits expected 0).
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts.
- out_instr  out  32  packed instruction.
- out_err  out  1  head entry failed range/alignment/format check.
- err_count  out  CNT_W  saturating count of errored encodes.
- rt_fail  out  1  sticky round-trip mismatch (macro only; else tied 0).

Behaviour:
- Reset (async, rst_n=0):
  - s1_valid=0, FIFO empty.
  - out_valid=0, out_instr=0, out_err=0, err_count=0, rt_fail=0.
  - Reset mid-operation discards all in-flight entries.
- Stage S1: captures fields on in_valid&&in_ready and packs them.
  - S1 advances into the FIFO when s1_valid && !fifo_full.
  - in_ready = !s1_valid || !fifo_full, combinational from registered state only.
- Latency: accept at edge N → out_valid at edge N+2 when FIFO empty and out_ready=1.
- Throughput: 1 per cycle sustained.
- Packing (opcode always in [6:0]):
  - R: funct7|rs2|rs1|funct3|rd.
  - I: imm[11:0]|rs1|funct3|rd.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0].
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11].
  - U: imm[31:12]|rd.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd.
- Error checks (out_err=1 when violated):
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - U: imm[11:0]=0.
  - fmt 6/7: always error, word = 0.
  - An errored entry still emits the truncated packed word; it is never dropped.
- err_count: increments on each errored S1→FIFO transfer; saturates at all-ones.
- FIFO:
  - Simultaneous push and pop when full is allowed only as pop-then-push; in_ready still follows fifo_full.
  - Pointer wrap at FIFO_DEPTH; no overflow or underflow under any handshake sequence.
- out_instr/out_err hold stable while out_valid && !out_ready.

Optional Feature:
- Macro: INSTR_ENC_ROUNDTRIP_CHK_EN.
- Defined: the S1 packed word is re-extracted to an immediate per format (sign-extended, B/J bit0=0). It is compared with in_imm for non-errored, non-R entries. Any mismatch sets rt_fail sticky until reset.
- Undefined: logic absent, rt_fail constant 0.

Decomposition:
- Shared package instr_enc_pkg holds:
  - fmt_e enum (R,I,S,B,U,J).
  - Opcode constants (OP_IMM, LUI, BRANCH, JAL, STORE, OP).
  - Struct enc_req_t bundling the input fields.
- One sub-module: enc_fifo (parameterised sync FIFO, async active-low reset, {32-bit word, err} payload).

Test Plan:
- ADDI: fmt=I, opcode=0x13, rd=1, rs1=0, f3=0, imm=0xFFFFFFFF → out_instr=0xFFF00093, out_err=0, appearing 2 cycles after accept.
- BEQ: fmt=B, opcode=0x63, rs1=rs2=0, f3=0, imm=8 → 0x00000463. With imm=9 → out_err=1, err_count=1.
- LUI: fmt=U, opcode=0x37, rd=5, imm=0x12345000 → 0x123452B7. With imm=0x12345001 → out_err=1.
- JAL: fmt=J, opcode=0x6F, rd=1, imm=0x800 → 0x001000EF. With imm=0x00100000 → out_err=1.
- Backpressure: out_ready=0 with 4 back-to-back requests → in_ready drops after FIFO_DEPTH+1=3 accepts. Release → words emerge in order with no loss or duplication.
- Reset asserted while FIFO holds 2 entries → out_valid=0 immediately. After release, a new ADDI emerges alone with err_count=0.
